alu_result_buffer: RTL
======================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, meaning FIFO entries; it SHALL be a power of two, 2..16.
REQ-002 The block SHALL take parameter CNT_W, default 8, meaning the overflow event counter width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream adder result is valid.
REQ-007 in_ready  output  1  buffer can accept a result.
REQ-008 in_z  input  16  adder sum Z.
REQ-009 in_flags  input  5  adder flags {Overflow,Parity,Carry,Zero,Sign}, bits 4..0.
REQ-010 out_valid  output  1  head entry is valid.
REQ-011 out_ready  input  1  consumer accepts the head entry.
REQ-012 out_z  output  16  head entry sum.
REQ-013 out_flags  output  5  head entry flags, same bit order as in_flags.
REQ-014 level  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-015 sticky_cv  output  2  {sticky overflow, sticky carry}.
REQ-016 ovf_count  output  CNT_W  saturating count of accepted results with Overflow=1.
REQ-017 clear_stat  input  1  synchronous clear of sticky_cv and ovf_count.

Function
REQ-018 A push SHALL occur on a clk edge when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-019 in_ready SHALL be 1 exactly when level < DEPTH; when full, no push SHALL occur even if a pop happens in the same cycle (no full-bypass).
REQ-020 out_valid SHALL be 1 exactly when level > 0; out_z/out_flags SHALL show the head entry combinationally (first-word fall-through).
REQ-021 Latency SHALL be one cycle: a result pushed at edge N SHALL appear with out_valid=1 after edge N when the FIFO was empty.
REQ-022 An empty FIFO SHALL not pass data through combinationally: an empty-cycle push SHALL NOT pop in that cycle.
REQ-023 A simultaneous push and pop SHALL leave level unchanged and preserve order.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; level SHALL be exact at 0 and DEPTH.
REQ-025 While out_valid=1 and out_ready=0, out_z/out_flags SHALL stay stable.
REQ-026 On a push, sticky_cv[1] SHALL set if in_flags[4]=1, and sticky_cv[0] SHALL set if in_flags[2]=1; bits SHALL otherwise hold.
REQ-027 On a push with in_flags[4]=1, ovf_count SHALL increment, saturating at 2^CNT_W-1.
REQ-028 When clear_stat=1 and a push occurs in the same cycle, clear SHALL apply first and the push event SHALL still be recorded (sticky set, count=1 on overflow).
REQ-029 clear_stat SHALL not affect FIFO contents, pointers or level.

Reset
REQ-030 On rst_n=0, independent of clk, the block SHALL force: level=0, out_valid=0, in_ready=1, sticky_cv=0, ovf_count=0, pointers=0.
REQ-031 Reset mid-operation SHALL discard all stored entries; storage contents need not be cleared, and out_z/out_flags are don't-care while out_valid=0.
REQ-032 Reset release SHALL take effect on the first clk edge after rst_n rises; no push SHALL be accepted on the releasing edge's preceding low phase.

Structure
REQ-033 A shared package alu_pkg SHALL hold the flag-bit index constants (FLG_S=0, FLG_Z=1, FLG_C=2, FLG_P=3, FLG_V=4), FLAG_W=5, DATA_W=16 and the entry typedef {flags,z}.
REQ-034 Storage SHALL be one sub-module, alu_fifo_mem: DEPTH x 21-bit, one write port and one asynchronous read port, with no reset on the array.
REQ-035 Pointer, level, sticky and counter logic SHALL reside in alu_result_buffer.

Verification
REQ-036 Reset, then push z=16'h8000 with flags=5'b10001 into an empty FIFO -> next cycle out_valid=1, out_z=16'h8000, out_flags=5'b10001, sticky_cv=2'b10, ovf_count=1.
REQ-037 With out_ready=0, push 4 results 16'h0001..16'h0004 -> level=4, in_ready=0; a 5th push is refused; then with out_ready=1 the outputs are 1,2,3,4 in order.
REQ-038 With the FIFO full, assert in_valid=1 and out_ready=1 for one cycle -> one pop and no push, so level=3; the next cycle pushes.
REQ-039 Push 300 results with Overflow=1 and CNT_W=8 -> ovf_count saturates at 255; clear_stat together with an overflow push -> ovf_count=1, sticky_cv[1]=1.
REQ-040 Run 8 push/pop cycles that wrap the pointers twice, then assert rst_n=0 asynchronously mid-cycle with level=2 -> immediately level=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared adder-result definitions: flag bit positions, widths and the FIFO entry layout.
package alu_pkg;

    localparam int unsigned FLG_S  = 0;
    localparam int unsigned FLG_Z  = 1;
    localparam int unsigned FLG_C  = 2;
    localparam int unsigned FLG_P  = 3;
    localparam int unsigned FLG_V  = 4;

    localparam int unsigned FLAG_W  = 5;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ENTRY_W = FLAG_W + DATA_W;

    // One buffered adder result: flags in the upper bits, sum in the lower bits.
    typedef struct packed {
        logic [FLAG_W-1:0] flags;
        logic [DATA_W-1:0] z;
    } entry_t;

endpackage : alu_pkg

// File: rtl/alu_fifo_mem.sv
// Result storage: DEPTH entries, one synchronous write port, one asynchronous read port.
module alu_fifo_mem
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  entry_t                     wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output entry_t                     rd_data
);

    entry_t mem [DEPTH];

    // Array is deliberately not reset; validity is tracked by the pointer logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read gives first-word fall-through at the head.
    always_comb begin
        rd_data = mem[rd_addr];
    end

endmodule : alu_fifo_mem

// File: rtl/alu_result_buffer.sv
// Buffers adder results in a FWFT FIFO and keeps sticky carry/overflow and an overflow counter.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_z,
    input  logic [FLAG_W-1:0]         in_flags,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_z,
    output logic [FLAG_W-1:0]         out_flags,
    output logic [$clog2(DEPTH):0]    level,
    output logic [1:0]                sticky_cv,
    output logic [CNT_W-1:0]          ovf_count,
    input  logic                      clear_stat
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic [LW-1:0]    level_nxt;
    logic [1:0]       sticky_nxt;
    logic [CNT_W-1:0] count_nxt;
    entry_t           wr_entry;
    entry_t           head;

    // Handshake qualifiers derived from the registered occupancy; a full FIFO never bypasses.
    always_comb begin
        in_ready  = (level < LW'(DEPTH));
        out_valid = (level != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        wr_entry  = '{flags: in_flags, z: in_z};
        out_z     = head.z;
        out_flags = head.flags;
    end

    alu_fifo_mem #(
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Next occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LW'(1);
        end else if (pop && !push) begin
            level_nxt = level - LW'(1);
        end
    end

    // Statistics: clear applies first, then the current push is recorded on top.
    always_comb begin
        sticky_nxt = clear_stat ? 2'b00 : sticky_cv;
        count_nxt  = clear_stat ? '0 : ovf_count;
        if (push) begin
            sticky_nxt[1] = sticky_nxt[1] | in_flags[FLG_V];
            sticky_nxt[0] = sticky_nxt[0] | in_flags[FLG_C];
            if (in_flags[FLG_V] && (count_nxt != CNT_MAX)) begin
                count_nxt = count_nxt + CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt;
        end
    end

    // Sticky flag and saturating overflow counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_cv <= 2'b00;
            ovf_count <= '0;
        end else begin
            sticky_cv <= sticky_nxt;
            ovf_count <= count_nxt;
        end
    end

endmodule : alu_result_buffer
